// File: rtl/seq_priority_encoder_if.sv
// Handshake bundle for seq_priority_encoder: request-vector input side and code output side.
// master = producer of vectors / consumer of codes; slave = the encoder.
interface seq_priority_encoder_if #(
    parameter int N = 7,
    parameter int W = 3
);
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] x;
    logic         mode;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] y;
    logic         out_last;

    modport master (
        output in_valid, x, mode, out_ready,
        input  in_ready, out_valid, y, out_last
    );

    modport slave (
        input  in_valid, x, mode, out_ready,
        output in_ready, out_valid, y, out_last
    );
endinterface

// File: rtl/seq_priority_encoder.sv
// Sequential priority encoder: captures a request vector and emits either one code
// (winning index + 1) or, in drain mode, one code per set bit in priority order.
module seq_priority_encoder #(
    parameter int N         = 7,
    parameter int W         = 3,
    parameter int MSB_FIRST = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    seq_priority_encoder_if.slave   bus
);
    if (N < 1 || N > 64) begin : g_bad_n
        $error("seq_priority_encoder: N must be in 1..64");
    end
    if ((2 ** W) <= N) begin : g_bad_w
        $error("seq_priority_encoder: 2**W must exceed N");
    end

    typedef enum logic {IDLE, EMIT} state_t;

    state_t       state;
    logic [N-1:0] pend;
    logic         mode_r;

    int           idx;
    logic [N-1:0] win;
    logic [W-1:0] code;
    logic         one_left;
    logic         emit;
    logic         last;
    logic         take;

    // Later assignments override earlier ones, so scan order sets the priority.
    always_comb begin
        idx = 0;
        if (MSB_FIRST != 0) begin
            for (int i = 0; i < N; i++) begin
                if (pend[i]) idx = i;
            end
        end else begin
            for (int i = N - 1; i >= 0; i--) begin
                if (pend[i]) idx = i;
            end
        end
    end

    for (genvar gi = 0; gi < N; gi++) begin : g_win
        assign win[gi] = (idx == gi);
    end

    assign code     = (pend == '0) ? '0 : W'(idx + 1);
    assign one_left = ($countones(pend) < 2);
    assign emit     = (state == EMIT);
    assign last     = emit && (!mode_r || one_left);
    assign take     = bus.in_valid && bus.in_ready;

    assign bus.out_valid = emit;
    assign bus.y         = emit ? code : '0;
    assign bus.out_last  = last;
    // Refill is allowed in the same cycle the final code is accepted.
    assign bus.in_ready  = (state == IDLE) || (last && bus.out_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            pend   <= '0;
            mode_r <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (take) begin
                        pend   <= bus.x;
                        mode_r <= bus.mode;
                        state  <= EMIT;
                    end
                end
                EMIT: begin
                    if (bus.out_ready) begin
                        if (!last) begin
                            pend <= pend & ~win;
                        end else if (take) begin
                            pend   <= bus.x;
                            mode_r <= bus.mode;
                        end else begin
                            pend  <= '0;
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_seq_priority_encoder.sv
// Directed bench: an MSB-first and an LSB-first encoder run in lockstep on the same stimulus.
module tb_seq_priority_encoder;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   n_tests = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    seq_priority_encoder_if #(.N(7), .W(3)) bm ();
    seq_priority_encoder_if #(.N(7), .W(3)) bl ();

    assign bl.in_valid  = bm.in_valid;
    assign bl.x         = bm.x;
    assign bl.mode      = bm.mode;
    assign bl.out_ready = bm.out_ready;

    seq_priority_encoder #(.N(7), .W(3), .MSB_FIRST(1)) dut_msb (.clk(clk), .rst_n(rst_n), .bus(bm));
    seq_priority_encoder #(.N(7), .W(3), .MSB_FIRST(0)) dut_lsb (.clk(clk), .rst_n(rst_n), .bus(bl));

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input string tag, input logic [6:0] xv, input logic m);
        check({tag, " in_ready"}, bm.in_ready, 1);
        bm.in_valid = 1'b1;
        bm.x        = xv;
        bm.mode     = m;
        cyc();
        bm.in_valid = 1'b0;
        bm.x        = '0;
        bm.mode     = 1'b0;
        $display("[TB] send %s x=%b mode=%0d", tag, xv, m);
    endtask

    task automatic pop(input string tag, input logic [2:0] ey, input logic elast, input logic [2:0] eyl);
        @(negedge clk);
        check({tag, " out_valid"}, bm.out_valid, 1);
        check({tag, " y"}, bm.y, ey);
        check({tag, " out_last"}, bm.out_last, elast);
        check({tag, " lsb y"}, bl.y, eyl);
        check({tag, " lsb out_last"}, bl.out_last, elast);
        $display("[TB] pop %s y=%0d last=%0d lsb_y=%0d", tag, bm.y, bm.out_last, bl.y);
        bm.out_ready = 1'b1;
        cyc();
        bm.out_ready = 1'b0;
    endtask

    task automatic idle_check(input string tag);
        @(negedge clk);
        check({tag, " idle out_valid"}, bm.out_valid, 0);
        check({tag, " idle y"}, bm.y, 0);
        check({tag, " idle in_ready"}, bm.in_ready, 1);
        $display("[TB] idle %s", tag);
    endtask

    initial begin
        bm.in_valid  = 1'b0;
        bm.x         = '0;
        bm.mode      = 1'b0;
        bm.out_ready = 1'b0;
        #1 rst_n = 1'b0;
        #2;
        check("rst out_valid", bm.out_valid, 0);
        check("rst y", bm.y, 0);
        check("rst out_last", bm.out_last, 0);
        check("rst in_ready", bm.in_ready, 1);
        $display("[TB] reset values checked");
        @(negedge clk);
        rst_n = 1'b1;

        // Zero vector captured on the first edge after reset release.
        send("zero", 7'b0000000, 1'b0);
        pop("zero", 3'd0, 1'b1, 3'd0);
        idle_check("zero");

        send("single", 7'b1010001, 1'b0);
        pop("single", 3'd7, 1'b1, 3'd1);
        idle_check("single");

        send("drain2", 7'b0010010, 1'b1);
        pop("drain2 a", 3'd5, 1'b0, 3'd2);
        pop("drain2 b", 3'd2, 1'b1, 3'd5);
        idle_check("drain2");

        // Back-pressure: code must hold for three stalled cycles.
        send("stall", 7'b1001111, 1'b1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stall out_valid", bm.out_valid, 1);
            check("stall y", bm.y, 7);
            check("stall out_last", bm.out_last, 0);
            check("stall in_ready", bm.in_ready, 0);
            $display("[TB] stall cycle %0d y=%0d", i, bm.y);
            cyc();
        end
        pop("stall 7", 3'd7, 1'b0, 3'd1);
        pop("stall 4", 3'd4, 1'b0, 3'd2);
        pop("stall 3", 3'd3, 1'b0, 3'd3);
        pop("stall 2", 3'd2, 1'b0, 3'd4);
        pop("stall 1", 3'd1, 1'b1, 3'd7);
        idle_check("stall");

        // Final handshake coincides with the next capture.
        send("refill a", 7'b1111101, 1'b0);
        @(negedge clk);
        check("refill a y", bm.y, 7);
        check("refill a out_last", bm.out_last, 1);
        bm.out_ready = 1'b1;
        bm.in_valid  = 1'b1;
        bm.x         = 7'b0001111;
        bm.mode      = 1'b0;
        #1;
        check("refill in_ready", bm.in_ready, 1);
        $display("[TB] refill handshake with in_ready=%0d", bm.in_ready);
        cyc();
        bm.out_ready = 1'b0;
        bm.in_valid  = 1'b0;
        bm.x         = '0;
        pop("refill b", 3'd4, 1'b1, 3'd1);
        idle_check("refill");

        // Reset in the middle of a drain abandons the vector.
        send("abort", 7'b1111111, 1'b1);
        pop("abort 7", 3'd7, 1'b0, 3'd1);
        pop("abort 6", 3'd6, 1'b0, 3'd2);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort out_valid", bm.out_valid, 0);
        check("abort y", bm.y, 0);
        check("abort out_last", bm.out_last, 0);
        check("abort in_ready", bm.in_ready, 1);
        $display("[TB] async reset during drain");
        cyc();
        @(negedge clk);
        rst_n = 1'b1;
        bm.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cyc();
            check("post-reset out_valid", bm.out_valid, 0);
            check("post-reset in_ready", bm.in_ready, 1);
        end
        bm.out_ready = 1'b0;
        send("after", 7'b0000100, 1'b1);
        pop("after", 3'd3, 1'b1, 3'd3);
        idle_check("after");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
